// File: rtl/prog_loader.sv
// prog_loader: word-serial program/data image loader.
// Each rising edge with Jen=1 captures one Jin word. The first DEPTH words go
// to data memory at addresses DEPTH-1 down to 0. The next DEPTH words go to
// instruction memory in the same order. The pipeline is held stalled while
// loading, and load_done flags that a complete image has been written.
//
// Handshake: Jen is a valid-only strobe and there is no backpressure. Every
// edge with Jen=1 is a capture. Jen=0 pauses the loader, with state and
// address held. The memory write strobes are presented for one cycle after
// the capture edge, and the memory commits the write on the following edge.
module prog_loader #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Jen,
    input  logic [WORD_W-1:0] Jin,
    output logic [WORD_W-1:0] Jout,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [WORD_W-1:0] dmem_wdata,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              load_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_D = 2'd1,
        LOAD_I = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_TOP = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

    state_t              state_q,      state_d;
    logic [ADDR_W-1:0]   cnt_q,        cnt_d;
    logic [WORD_W-1:0]   jout_q,       jout_d;
    logic                dmem_we_q,    dmem_we_d;
    logic [ADDR_W-1:0]   dmem_addr_q,  dmem_addr_d;
    logic [WORD_W-1:0]   dmem_wdata_q, dmem_wdata_d;
    logic                imem_we_q,    imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q,  imem_addr_d;
    logic [WORD_W-1:0]   imem_wdata_q, imem_wdata_d;
    logic                cpu_hold_q,   cpu_hold_d;
    logic                load_done_q,  load_done_d;

    // Next-state and registered-output logic. A capture always writes at the
    // current count. The count reloads at 0 and never wraps.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        jout_d       = jout_q;
        dmem_we_d    = 1'b0;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_hold_d   = cpu_hold_q;
        load_done_d  = load_done_q;

        if (Jen) begin
            jout_d      = Jin;
            // Every capture leads into loading or is the final imem strobe
            // cycle, so the stall stays up through it.
            cpu_hold_d  = 1'b1;
            load_done_d = 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    // cnt already sits at DEPTH-1 here (reset value or reload).
                    dmem_we_d    = 1'b1;
                    dmem_addr_d  = cnt_q;
                    dmem_wdata_d = Jin;
                    cnt_d        = cnt_q - CNT_ONE;
                    state_d      = LOAD_D;
                end
                LOAD_D: begin
                    dmem_we_d    = 1'b1;
                    dmem_addr_d  = cnt_q;
                    dmem_wdata_d = Jin;
                    if (cnt_q == '0) begin
                        cnt_d   = CNT_TOP;
                        state_d = LOAD_I;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                LOAD_I: begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = cnt_q;
                    imem_wdata_d = Jin;
                    if (cnt_q == '0) begin
                        cnt_d   = CNT_TOP;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = CNT_TOP;
                end
            endcase
        end else begin
            // Pause: nothing advances. The stall reflects whether a load is in
            // progress, and done rises on the edge that commits the last write.
            cpu_hold_d = (state_q == LOAD_D) || (state_q == LOAD_I);
            if (state_q == DONE) begin
                load_done_d = 1'b1;
            end
        end
    end

    // State and output registers. Reset drops all strobes immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= CNT_TOP;
            jout_q       <= '0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            jout_q       <= jout_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            load_done_q  <= load_done_d;
        end
    end

    assign Jout       = jout_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign load_done  = load_done_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed plus randomized checks of prog_loader against an
// index-based reference model. Word k of an image lands at dmem[DEPTH-1-k]
// or at imem[2*DEPTH-1-k].
module tb_prog_loader;

    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;
    localparam int WORD_W = 32;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              Jen = 1'b0;
    logic [WORD_W-1:0] Jin = '0;
    logic [WORD_W-1:0] Jout;
    logic              dmem_we, imem_we, cpu_hold, load_done;
    logic [ADDR_W-1:0] dmem_addr, imem_addr;
    logic [WORD_W-1:0] dmem_wdata, imem_wdata;

    always #5 clk = ~clk;

    prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .Jen        (Jen),
        .Jin        (Jin),
        .Jout       (Jout),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done)
    );

    // ---------------- model / scoreboard state ----------------
    int                n_checks = 0;
    int                n_fails  = 0;
    int                k        = 0;     // words captured in the current image
    logic [WORD_W-1:0] last_word = '0;
    int                hold_cycles = 0;
    logic [WORD_W-1:0] tb_dmem [DEPTH];  // what the DUT strobes wrote
    logic [WORD_W-1:0] tb_imem [DEPTH];
    logic [WORD_W-1:0] exp_dmem[DEPTH];  // what the image should contain
    logic [WORD_W-1:0] exp_imem[DEPTH];

    task automatic check(input string tag, input logic [WORD_W-1:0] obs,
                         input logic [WORD_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dmem_we"},    32'(dmem_we),    '0);
        check({tag, "_imem_we"},    32'(imem_we),    '0);
        check({tag, "_dmem_addr"},  32'(dmem_addr),  '0);
        check({tag, "_imem_addr"},  32'(imem_addr),  '0);
        check({tag, "_dmem_wdata"}, dmem_wdata,      '0);
        check({tag, "_imem_wdata"}, imem_wdata,      '0);
        check({tag, "_cpu_hold"},   32'(cpu_hold),   '0);
        check({tag, "_load_done"},  32'(load_done),  '0);
        check({tag, "_jout"},       Jout,            '0);
    endtask

    task automatic clear_images();
        for (int i = 0; i < DEPTH; i++) begin
            tb_dmem[i]  = 'x;
            tb_imem[i]  = 'x;
            exp_dmem[i] = 'x;
            exp_imem[i] = 'x;
        end
    endtask

    // ---------------- driver: one clock with model update and checks ----------------
    task automatic step(input bit en, input logic [WORD_W-1:0] w);
        bit exp_d, exp_i, exp_hold, exp_done;
        int idx;
        exp_d = 1'b0;
        exp_i = 1'b0;
        idx   = 0;
        @(negedge clk);
        Jen = en;
        Jin = w;
        @(posedge clk);
        #1;
        if (dmem_we) tb_dmem[dmem_addr] = dmem_wdata;
        if (imem_we) tb_imem[imem_addr] = imem_wdata;
        if (cpu_hold) hold_cycles++;

        if (en) begin
            if (k == 2 * DEPTH) k = 0;       // capture from DONE starts a new image
            exp_d = (k < DEPTH);
            exp_i = !exp_d;
            idx   = exp_d ? (DEPTH - 1 - k) : (2 * DEPTH - 1 - k);
            if (exp_d) exp_dmem[idx] = w;
            else       exp_imem[idx] = w;
            k++;
            last_word = w;
        end
        exp_hold = en ? 1'b1 : (k > 0 && k < 2 * DEPTH);
        exp_done = !en && (k == 2 * DEPTH);

        check("dmem_we",   32'(dmem_we),   32'(exp_d));
        check("imem_we",   32'(imem_we),   32'(exp_i));
        check("we_excl",   32'(dmem_we & imem_we), '0);
        check("cpu_hold",  32'(cpu_hold),  32'(exp_hold));
        check("load_done", 32'(load_done), 32'(exp_done));
        check("jout",      Jout,           last_word);
        if (exp_d) begin
            check("dmem_addr",  32'(dmem_addr), 32'(idx));
            check("dmem_wdata", dmem_wdata,     w);
        end
        if (exp_i) begin
            check("imem_addr",  32'(imem_addr), 32'(idx));
            check("imem_wdata", imem_wdata,     w);
        end
    endtask

    task automatic load_random(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 7) == 0)
                repeat ($urandom_range(1, 3)) step(1'b0, $urandom);
            step(1'b1, $urandom);
        end
    endtask

    task automatic check_image(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tb_dmem[i] !== exp_dmem[i]) bad++;
            if (tb_imem[i] !== exp_imem[i]) bad++;
        end
        check(tag, 32'(bad), '0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        clear_images();

        // Reset held with Jen active: nothing may come out.
        repeat (3) begin
            @(negedge clk);
            Jen = 1'b1;
            Jin = $urandom;
            @(posedge clk);
            #1;
            check_zero("reset");
        end
        @(negedge clk);
        rst = 1'b1;
        Jen = 1'b0;
        step(1'b0, $urandom);

        // Full load with a counting pattern.
        hold_cycles = 0;
        for (int i = 0; i < 2 * DEPTH; i++) step(1'b1, 32'h1000_0000 + i);
        step(1'b0, $urandom);
        check("hold_cycles", 32'(hold_cycles), 32'(2 * DEPTH));
        check_image("image_full");

        // Restart from DONE after an idle stretch.
        repeat (10) step(1'b0, $urandom);
        step(1'b1, 32'hDEAD_BEEF);
        check("restart_jout", Jout, 32'hDEAD_BEEF);

        // Finish the image with pauses at word 300 and at the dmem/imem boundary.
        for (int i = 1; i < 2 * DEPTH; i++) begin
            if (i == 300 || i == DEPTH) repeat (5) step(1'b0, $urandom);
            step(1'b1, 32'h1000_0000 + i);
        end
        step(1'b0, $urandom);
        check_image("image_pause");

        // Reset in the middle of a randomized load.
        clear_images();
        step(1'b1, $urandom);              // start a new image from DONE
        load_random(699, 1'b1);
        #2 rst = 1'b0;
        #1 check_zero("async_rst");
        repeat (3) begin
            @(negedge clk);
            Jen = 1'b1;
            Jin = $urandom;
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        @(negedge clk);
        rst       = 1'b1;
        Jen       = 1'b0;
        k         = 0;
        last_word = '0;
        clear_images();

        // Full randomized reload with random pauses.
        load_random(2 * DEPTH, 1'b1);
        repeat (2) step(1'b0, $urandom);
        check_image("image_reload");

        // Reset while DONE clears load_done.
        @(negedge clk);
        rst = 1'b0;
        #1 check("done_rst", 32'(load_done), '0);
        @(negedge clk);
        rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
